// File: rtl/risc_pkg.sv
// Shared constants and types for the RISC front end.
package risc_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is read combinationally so
// the consumer sees data in the cycle after the push.
module fetch_fifo
  import risc_pkg::*;
#(
  parameter int  DEPTH     = 2,
  parameter type T         = fetch_entry_t,
  parameter T    RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  // A push at full is accepted only when the same cycle frees a slot.
  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && ((r_count != DEPTH_C) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == DEPTH_C);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, pc-tag queue and
// instruction buffer feeding decode; redirects flush everything in flight.
module fetch_stage
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
  localparam fetch_entry_t BUF_RESET = '{pc: RESET_PC, instr: NOP_INSTR};

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_buf_count;
  logic [CW-1:0] w_tag_count;
  logic          w_buf_empty;
  logic          w_buf_full;
  logic          w_tag_empty;
  logic          w_tag_full;
  logic [31:0]   w_tag_pc;
  fetch_entry_t  w_buf_in;
  fetch_entry_t  w_buf_head;
  logic [CW:0]   w_credits_used;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_rsp_keep;
  logic          w_pop;

  // Every request owns a buffer slot up front, so responses never stall.
  assign w_credits_used = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign imem_req_valid = !rst && !redirect_valid && (w_credits_used < DEPTH_W);
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_fire     = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep     = w_rsp_fire && (r_drop == '0) && !redirect_valid;
  assign w_pop          = if_valid && if_ready;
  assign w_buf_in       = '{pc: w_tag_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (redirect_valid) begin
        r_pc   <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle is stale.
        r_drop <= r_outstanding - CW'(w_rsp_fire);
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_rsp_fire && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .T         (logic [31:0]),
    .RESET_VAL (RESET_PC)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (w_req_fire),
    .push_data (r_pc),
    .pop       (w_rsp_fire && (r_drop == '0)),
    .flush     (redirect_valid),
    .pop_data  (w_tag_pc),
    .full      (w_tag_full),
    .empty     (w_tag_empty),
    .count     (w_tag_count)
  );

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .T         (fetch_entry_t),
    .RESET_VAL (BUF_RESET)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_rsp_keep),
    .push_data (w_buf_in),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .pop_data  (w_buf_head),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  assign if_valid    = !w_buf_empty;
  assign if_pc       = w_buf_head.pc;
  assign if_instr    = w_buf_head.instr;
  assign if_pc_plus4 = w_buf_head.pc + 32'd4;

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (r_outstanding == '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (w_credits_used <= DEPTH_W) && (({1'b0, w_tag_count} + {1'b0, w_buf_count}) <= DEPTH_W));
  a_tag_present: assert property (@(posedge clk) disable iff (rst)
    !(w_rsp_fire && (r_drop == '0) && w_tag_empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_buf_full && w_rsp_keep && !w_pop) && !(w_tag_full && w_req_fire));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order imem model.
module tb_fetch_stage;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];
  int          cyc;
  int          lat;
  int          n_req;
  int          n_checks;
  int          n_fail;
  int          idx;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, observe 1ns later, well before posedge.
  // The imem answers each request with the inverted address.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic r);
    @(negedge clk);
    rst            = r;
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (r) pend_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!r && pend_q.size() > 0) begin
      if (pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend_q[0].addr;
      end
    end
    #1;
    if (imem_rsp_valid) void'(pend_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_addr, due: cyc + lat});
      n_req++;
    end
    if (if_valid && if_ready) begin
      log_pc.push_back(if_pc);
      log_instr.push_back(if_instr);
      $display("cyc %0d: decode takes pc=%h instr=%h", cyc, if_pc, if_instr);
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input int l);
    lat = l;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    log_pc.delete();
    log_instr.delete();
    n_req = 0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    n_req    = 0;

    // Reset values
    do_reset(1);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("rst_if_valid",  32'(if_valid),       32'h0);
    check_eq("rst_if_instr",  if_instr,            32'h0000_0013);
    check_eq("rst_if_pc",     if_pc,               32'h0);
    check_eq("rst_pc_plus4",  if_pc_plus4,         32'h4);
    check_eq("rst_addr",      imem_addr,           32'h0);

    // 1: L=1 streaming
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t1_req_c0",  32'(imem_req_valid), 32'h1);
    check_eq("t1_addr_c0", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t1_ifv_c1", 32'(if_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t1_ifv_c2",   32'(if_valid), 32'h1);
    check_eq("t1_pc_c2",    if_pc, 32'h0);
    check_eq("t1_plus4_c2", if_pc_plus4, 32'h4);
    check_eq("t1_instr_c2", if_instr, 32'hFFFF_FFFF);
    run(12, 1'b1);
    check_eq("t1_count_ge6", 32'(log_pc.size() >= 6), 32'h1);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t1_pc%0d", i), log_pc[i], 32'(4 * i));
      check_eq($sformatf("t1_instr%0d", i), log_instr[i], ~32'(4 * i));
    end

    // 2: decode stall
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (k >= 2) begin
        check_eq($sformatf("t2_pc_hold%0d", k), if_pc, 32'h0);
        check_eq($sformatf("t2_instr_hold%0d", k), if_instr, 32'hFFFF_FFFF);
      end
    end
    check_eq("t2_req_count",   32'(n_req), 32'h2);
    check_eq("t2_req_dropped", 32'(imem_req_valid), 32'h0);
    check_eq("t2_if_valid",    32'(if_valid), 32'h1);
    check_eq("t2_no_pop",      32'(log_pc.size()), 32'h0);
    run(12, 1'b1);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_pc%0d", i), log_pc[i], 32'(4 * i));

    // 3: L=3, redirect with two requests in flight
    do_reset(3);
    run(2, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    check_eq("t3_in_flight", 32'(n_req), 32'h2);
    check_eq("t3_no_req",    32'(imem_req_valid), 32'h0);
    run(20, 1'b1);
    check_eq("t3_pc0",    log_pc[0], 32'h100);
    check_eq("t3_pc1",    log_pc[1], 32'h104);
    check_eq("t3_pc2",    log_pc[2], 32'h108);
    check_eq("t3_instr0", log_instr[0], ~32'h100);

    // 4: redirect coincident with response and decode pop
    do_reset(1);
    run(2, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b0);
    check_eq("t4_pop_pc", if_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t4_ifv_after", 32'(if_valid), 32'h0);
    check_eq("t4_req_after", 32'(imem_req_valid), 32'h1);
    check_eq("t4_addr_after", imem_addr, 32'h40);
    run(12, 1'b1);
    check_eq("t4_pc0", log_pc[0], 32'h0);
    check_eq("t4_pc1", log_pc[1], 32'h40);
    check_eq("t4_pc2", log_pc[2], 32'h44);

    // 5: back-to-back redirects, then a misaligned target
    do_reset(3);
    run(2, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0);
    check_eq("t5_no_req", 32'(imem_req_valid), 32'h0);
    run(20, 1'b1);
    check_eq("t5_pc0", log_pc[0], 32'h300);
    check_eq("t5_pc1", log_pc[1], 32'h304);
    check_eq("t5_pc2", log_pc[2], 32'h308);
    step(1'b1, 1'b1, 32'h203, 1'b0);
    idx = log_pc.size();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t5_addr_203", imem_addr, 32'h200);
    run(20, 1'b1);
    check_eq("t5_first_203", log_pc[idx], 32'h200);

    // 6: PC wrap and mid-stream reset
    do_reset(1);
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t6_req_top",  32'(imem_req_valid), 32'h1);
    check_eq("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t6_addr_wrap", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("t6_if_pc",    if_pc, 32'hFFFF_FFFC);
    check_eq("t6_plus4",    if_pc_plus4, 32'h0);
    check_eq("t6_instr",    if_instr, 32'h0000_0003);
    run(4, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("t6_rst_req",   32'(imem_req_valid), 32'h0);
    check_eq("t6_rst_ifv",   32'(if_valid), 32'h0);
    check_eq("t6_rst_instr", if_instr, 32'h0000_0013);
    check_eq("t6_rst_pc",    if_pc, 32'h0);
    check_eq("t6_rst_addr",  imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
